// File: rtl/instr_wb_master_if.sv
// Pipelined Wishbone B4 bus bundle between the instrumentation master and a slave.
// Signal names keep the master-relative _o/_i suffixes of the port list.
interface instr_wb_master_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_cyc_o;
    logic        wb_stall_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i, wb_stall_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i, wb_stall_i
    );
endinterface

// File: rtl/instr_wb_master.sv
// Single-transfer pipelined Wishbone B4 master driven by an instrumentation request,
// with a per-transfer cycle budget that aborts transfers whose slave never acknowledges.
module instr_wb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    instr_wb_master_if.master    bus,
    input  logic                 request_i,
    input  logic [31:0]          req_adr_i,
    input  logic [31:0]          req_dat_i,
    input  logic                 req_we_i,
    input  logic [3:0]           req_sel_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [31:0]          read_data_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQUEST  = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    // Counter value seen on the last edge a transfer may still hold the bus.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [31:0] adr_r;
    logic [31:0] dat_r;
    logic        we_r;
    logic [3:0]  sel_r;
    logic        stb_r;
    logic        cyc_r;
    logic        busy_r;
    logic        done_r;
    logic        timeout_r;
    logic [31:0] rdata_r;
    logic        ack_s;

    // An ack only counts once the request has been accepted (or is accepted on this same edge).
    assign ack_s = bus.wb_ack_i && ((state_r == ST_WAIT_ACK) || !bus.wb_stall_i);

    assign bus.wb_adr_o = adr_r;
    assign bus.wb_dat_o = dat_r;
    assign bus.wb_we_o  = we_r;
    assign bus.wb_sel_o = sel_r;
    assign bus.wb_stb_o = stb_r;
    assign bus.wb_cyc_o = cyc_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign timeout_o    = timeout_r;
    assign read_data_o  = rdata_r;

    // Transfer FSM with all bus and status outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            adr_r     <= 32'd0;
            dat_r     <= 32'd0;
            we_r      <= 1'b0;
            sel_r     <= 4'd0;
            stb_r     <= 1'b0;
            cyc_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            rdata_r   <= 32'd0;
        end else begin
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (request_i) begin
                        adr_r   <= req_adr_i;
                        dat_r   <= req_dat_i;
                        we_r    <= req_we_i;
                        sel_r   <= req_sel_i;
                        stb_r   <= 1'b1;
                        cyc_r   <= 1'b1;
                        busy_r  <= 1'b1;
                        cnt_r   <= 8'd0;
                        state_r <= ST_REQUEST;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQUEST, ST_WAIT_ACK: begin
                    if (ack_s) begin
                        // Ack beats a timeout that falls on the same edge.
                        stb_r   <= 1'b0;
                        cyc_r   <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        if (!we_r) begin
                            rdata_r <= bus.wb_dat_i;
                        end else begin
                            rdata_r <= rdata_r;
                        end
                        state_r <= ST_IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        stb_r     <= 1'b0;
                        cyc_r     <= 1'b0;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        timeout_r <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                        if ((state_r == ST_REQUEST) && !bus.wb_stall_i) begin
                            stb_r   <= 1'b0;
                            state_r <= ST_WAIT_ACK;
                        end else begin
                            state_r <= state_r;
                        end
                    end
                end
                default: begin
                    stb_r   <= 1'b0;
                    cyc_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    cnt_r   <= 8'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_wb_master.sv
// Bench for instr_wb_master: directed bus scenarios plus a randomized slave,
// all checked every cycle against a transaction-level model of the master.
module tb_instr_wb_master;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        request = 1'b0;
    logic [31:0] req_adr = 32'd0;
    logic [31:0] req_dat = 32'd0;
    logic        req_we = 1'b0;
    logic [3:0]  req_sel = 4'd0;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] read_data;

    instr_wb_master_if bus ();

    instr_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus),
        .request_i   (request),
        .req_adr_i   (req_adr),
        .req_dat_i   (req_dat),
        .req_we_i    (req_we),
        .req_sel_i   (req_sel),
        .busy_o      (busy),
        .done_o      (done),
        .timeout_o   (timeout),
        .read_data_o (read_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Transaction-level model: what the bus must show, plus how long cyc has been up.
    logic        m_cyc, m_stb, m_we, m_busy, m_done, m_tmo;
    logic [31:0] m_adr, m_dat, m_rdata;
    logic [3:0]  m_sel;
    int          m_high;
    int          cyc_obs, stb_obs, done_obs;
    logic        silent;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_busy = 1'b0;
        m_done = 1'b0; m_tmo = 1'b0; m_adr = 32'd0; m_dat = 32'd0;
        m_rdata = 32'd0; m_sel = 4'd0; m_high = 0;
    endtask

    task automatic model_edge();
        m_done = 1'b0;
        m_tmo  = 1'b0;
        if (!m_busy) begin
            if (request) begin
                m_adr = req_adr; m_dat = req_dat; m_we = req_we; m_sel = req_sel;
                m_cyc = 1'b1; m_stb = 1'b1; m_busy = 1'b1; m_high = 0;
            end
        end else begin
            m_high++;
            if (bus.wb_ack_i && !(m_stb && bus.wb_stall_i)) begin
                m_cyc = 1'b0; m_stb = 1'b0; m_busy = 1'b0; m_done = 1'b1;
                if (!m_we) m_rdata = bus.wb_dat_i;
            end else if (m_high == TO) begin
                m_cyc = 1'b0; m_stb = 1'b0; m_busy = 1'b0; m_done = 1'b1; m_tmo = 1'b1;
            end else if (m_stb && !bus.wb_stall_i) begin
                m_stb = 1'b0;
            end
        end
    endtask

    task automatic compare();
        chk1("cyc", bus.wb_cyc_o, m_cyc);
        chk1("stb", bus.wb_stb_o, m_stb);
        chk1("we", bus.wb_we_o, m_we);
        chk("adr", bus.wb_adr_o, m_adr);
        chk("dat", bus.wb_dat_o, m_dat);
        chk("sel", {28'd0, bus.wb_sel_o}, {28'd0, m_sel});
        chk1("busy", busy, m_busy);
        chk1("done", done, m_done);
        chk1("timeout", timeout, m_tmo);
        chk("read_data", read_data, m_rdata);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        compare();
        if (bus.wb_cyc_o) cyc_obs++;
        if (bus.wb_stb_o) stb_obs++;
        if (done) done_obs++;
    endtask

    task automatic slave(input logic ack, input logic stall, input logic [31:0] d);
        bus.wb_ack_i   = ack;
        bus.wb_stall_i = stall;
        bus.wb_dat_i   = d;
    endtask

    task automatic req(input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic [3:0] s);
        request = r; req_adr = a; req_dat = d; req_we = w; req_sel = s;
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk1("async_rst_cyc", bus.wb_cyc_o, 1'b0);
        chk1("async_rst_busy", busy, 1'b0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        slave(1'b0, 1'b0, 32'd0);
        cyc_obs = 0; stb_obs = 0; done_obs = 0; silent = 1'b0;
        #12;
        compare();
        chk("rst_adr_lit", bus.wb_adr_o, 32'd0);
        chk1("rst_cyc_lit", bus.wb_cyc_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Read, slave accepts at once and acks one cycle after stb.
        req(1'b1, 32'h0000_1000, 32'h0, 1'b0, 4'hF);
        stb_obs = 0;
        step();
        req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        step();
        slave(1'b1, 1'b0, 32'hDEAD_BEEF);
        step();
        chk1("rd_done_lit", done, 1'b1);
        chk1("rd_tmo_lit", timeout, 1'b0);
        chk("rd_data_lit", read_data, 32'hDEAD_BEEF);
        chk("rd_stb_cycles_lit", 32'(stb_obs), 32'd1);
        slave(1'b0, 1'b0, 32'h0);
        step();

        // Write held off by three stall cycles; req_* wiggle must not leak onto the bus.
        req(1'b1, 32'h0000_2004, 32'h1234_5678, 1'b1, 4'h3);
        stb_obs = 0;
        step();
        slave(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            req(1'b1, $urandom, $urandom, 1'b0, 4'hC);
            step();
            chk("wr_adr_lit", bus.wb_adr_o, 32'h0000_2004);
            chk("wr_dat_lit", bus.wb_dat_o, 32'h1234_5678);
        end
        req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        slave(1'b0, 1'b0, 32'h0);
        step();
        chk("wr_stb_cycles_lit", 32'(stb_obs), 32'd4);
        slave(1'b1, 1'b0, 32'h5555_AAAA);
        step();
        chk1("wr_done_lit", done, 1'b1);
        chk("wr_rdata_kept_lit", read_data, 32'hDEAD_BEEF);
        slave(1'b0, 1'b0, 32'h0);
        step();

        // Slave never acks: cyc must stay up exactly TO cycles before the abort.
        req(1'b1, 32'h0000_3000, 32'h0, 1'b0, 4'hF);
        cyc_obs = 0;
        step();
        req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) break;
        end
        chk("tmo_cyc_cycles_lit", 32'(cyc_obs), 32'd16);
        chk1("tmo_done_lit", done, 1'b1);
        chk1("tmo_flag_lit", timeout, 1'b1);
        chk1("tmo_busy_lit", busy, 1'b0);
        step();

        // Ack on the last allowed edge beats the timeout.
        req(1'b1, 32'h0000_4000, 32'h0, 1'b0, 4'hF);
        step();
        req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        for (int i = 0; i < 15; i++) step();
        slave(1'b1, 1'b0, 32'hCAFE_0015);
        step();
        chk1("late_ack_done_lit", done, 1'b1);
        chk1("late_ack_tmo_lit", timeout, 1'b0);
        chk("late_ack_data_lit", read_data, 32'hCAFE_0015);
        slave(1'b0, 1'b0, 32'h0);
        step();

        // Request held high, slave acks on the accepting edge: a transfer every two cycles.
        req(1'b1, 32'h0000_5000, 32'h0, 1'b0, 4'hF);
        slave(1'b1, 1'b0, 32'h0BAD_F00D);
        done_obs = 0;
        for (int i = 0; i < 9; i++) step();
        chk("b2b_done_count_lit", 32'(done_obs), 32'd4);
        req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        slave(1'b0, 1'b0, 32'h0);
        step();
        step();

        // Reset while waiting for ack: no done pulse, next transfer is normal.
        req(1'b1, 32'h0000_6000, 32'h0, 1'b0, 4'hF);
        step();
        req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        step();
        step();
        pulse_reset();
        slave(1'b1, 1'b0, 32'h1111_2222);
        step();
        chk1("post_rst_no_done_lit", done, 1'b0);
        req(1'b1, 32'h0000_7000, 32'h0, 1'b0, 4'hF);
        slave(1'b0, 1'b0, 32'h0);
        step();
        req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        slave(1'b1, 1'b0, 32'h7777_0001);
        step();
        chk1("post_rst_done_lit", done, 1'b1);
        chk("post_rst_data_lit", read_data, 32'h7777_0001);
        slave(1'b0, 1'b0, 32'h0);
        step();

        // Random slave behaviour, including silent slaves and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (m_busy && m_high == 0) silent = ($urandom_range(0, 5) == 0);
            req(1'($urandom_range(0, 1)), $urandom, $urandom,
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            if (m_busy && m_stb) begin
                bus.wb_stall_i = ($urandom_range(0, 2) == 0);
                bus.wb_ack_i   = !bus.wb_stall_i && ($urandom_range(0, 7) == 0);
            end else if (m_busy) begin
                bus.wb_stall_i = 1'($urandom_range(0, 1));
                bus.wb_ack_i   = !silent && ($urandom_range(0, 3) == 0);
            end else begin
                bus.wb_stall_i = 1'($urandom_range(0, 1));
                bus.wb_ack_i   = ($urandom_range(0, 5) == 0);
            end
            bus.wb_dat_i = $urandom;
            step();
            if (i % 997 == 500) pulse_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_wb_master.md
INSTR_WB_MASTER -- requirements
Module: instr_wb_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16; max cycles a transfer may hold wb_cyc_o before abort; legal range 2..255.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 wb_adr_o  output  32  Wishbone address.
REQ-005 wb_dat_o  output  32  Wishbone write data.
REQ-006 wb_dat_i  input  32  Wishbone read data.
REQ-007 wb_we_o  output  1  write enable; 1 = write, 0 = read.
REQ-008 wb_sel_o  output  4  byte select.
REQ-009 wb_stb_o  output  1  strobe.
REQ-010 wb_ack_i  input  1  acknowledge.
REQ-011 wb_cyc_o  output  1  cycle.
REQ-012 wb_stall_i  input  1  pipelined stall.
REQ-013 request_i  input  1  instrumentation: start one transfer when high and not busy.
REQ-014 req_adr_i / req_dat_i / req_we_i / req_sel_i  input  32/32/1/4  transfer parameters, sampled with request_i.
REQ-015 busy_o  output  1  high from the cycle after acceptance until done_o.
REQ-016 done_o  output  1  one-cycle completion pulse.
REQ-017 timeout_o  output  1  qualifies done_o; 1 = aborted by timeout.
REQ-018 read_data_o  output  32  data captured on read ack; holds until next read completion.

Function
REQ-019 Single-transfer pipelined Wishbone B4 master; FSM states IDLE, REQUEST, WAIT_ACK; all outputs registered.
REQ-020 IDLE: request_i=1 at edge -> latch req_* into wb_adr_o/wb_dat_o/wb_we_o/wb_sel_o, set wb_cyc_o=wb_stb_o=1, busy_o=1, clear timeout counter, go REQUEST (1-cycle latency request_i -> stb).
REQ-021 request_i while busy_o=1 ignored; no queueing; req_* changes during a transfer do not affect the bus.
REQ-022 REQUEST: wb_stall_i=1 -> hold all bus outputs unchanged; wb_stall_i=0 -> request accepted, drop wb_stb_o next cycle, go WAIT_ACK.
REQ-023 REQUEST with wb_stall_i=0 and wb_ack_i=1 same edge -> treat as accepted and acknowledged; complete per REQ-025, go IDLE.
REQ-024 WAIT_ACK: wb_cyc_o=1, wb_stb_o=0; wait for wb_ack_i.
REQ-025 Completion on wb_ack_i=1: next cycle wb_cyc_o=0, busy_o=0, done_o=1 for one cycle, timeout_o=0; if wb_we_o=0 read_data_o <= wb_dat_i; state IDLE.
REQ-026 A request_i in the cycle done_o=1 is accepted (back-to-back, one idle cycle with wb_cyc_o=0 between transfers).
REQ-027 Timeout counter 8-bit, increments each cycle in REQUEST or WAIT_ACK; when it equals TIMEOUT_CYCLES-1 and no ack that edge -> next cycle wb_cyc_o=0, wb_stb_o=0, done_o=1, timeout_o=1, read_data_o unchanged, IDLE.
REQ-028 Ack and timeout on same edge -> ack wins (normal completion, timeout_o=0).
REQ-029 wb_ack_i while in IDLE ignored; no output changes.
REQ-030 timeout_o is valid only with done_o; it SHALL be 0 whenever done_o=0.

Reset
REQ-031 rst_ni=0 asynchronously forces IDLE, counter 0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=wb_dat_o=0, wb_sel_o=0, busy_o=done_o=timeout_o=0, read_data_o=0.
REQ-032 Reset mid-transfer aborts immediately with no done_o pulse; first request after release of rst_ni behaves as from IDLE.

Verification
REQ-033 Read, no stall: request_i with adr=0x0000_1000, we=0, sel=0xF; slave acks 1 cycle after stb with dat=0xDEAD_BEEF -> stb high exactly 1 cycle, done_o pulse, read_data_o=0xDEAD_BEEF, timeout_o=0.
REQ-034 Write with 3 stall cycles: dat=0x1234_5678, sel=0x3 -> stb/adr/dat/sel stable for 4 cycles, stb drops after stall low, done_o after ack, read_data_o unchanged.
REQ-035 Timeout: TIMEOUT_CYCLES=16, slave never acks -> wb_cyc_o high exactly 16 cycles, then done_o=1 with timeout_o=1, busy_o=0.
REQ-036 Back-to-back: request_i held high continuously -> second transfer stb asserted the cycle after done_o; request_i pulses while busy produce no extra transfers.
REQ-037 Reset mid-WAIT_ACK: drop rst_ni for 1 cycle -> wb_cyc_o=0 asynchronously, no done_o, next request completes normally.
REQ-038 Same-edge ack and stall-release in REQUEST, and ack at counter=15 -> normal completion, timeout_o=0.
